// File: rtl/exception_controller_pkg.sv
// Shared CP0 constants, exception codes and sequencing state encoding for the
// exception controller and its register file.
package exception_controller_pkg;

  localparam logic [4:0] Cp0AddrSr    = 5'd12;
  localparam logic [4:0] Cp0AddrCause = 5'd13;
  localparam logic [4:0] Cp0AddrEpc   = 5'd14;
  localparam logic [4:0] Cp0AddrPrid  = 5'd15;

  localparam logic [4:0] ExcInt  = 5'd0;
  localparam logic [4:0] ExcAdEL = 5'd4;
  localparam logic [4:0] ExcAdES = 5'd5;
  localparam logic [4:0] ExcRI   = 5'd10;
  localparam logic [4:0] ExcOv   = 5'd12;

  localparam logic [31:0] PridValue          = 32'h4D49_5053;
  localparam logic [31:0] DefaultHandlerAddr = 32'h0000_4180;

  typedef enum logic [0:0] {
    StRun   = 1'b0,
    StFlush = 1'b1
  } state_e;

endpackage

// File: rtl/exception_controller_if.sv
// Pipeline-facing signal bundle of the exception controller; the pipeline is
// the master, the controller the slave.
interface exception_controller_if;
  logic [5:0]  hw_int;
  logic        m_valid;
  logic [31:0] pc_m;
  logic        bd_m;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic        eret_m;
  logic        cp0_we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic        interrupt;
  logic        exception;
  logic        eret_go;
  logic [31:0] EPC;
  logic [31:0] handler_addr;
  logic        flush;

  modport master (
    output hw_int, m_valid, pc_m, bd_m, exc_valid, exc_code, eret_m,
           cp0_we, cp0_addr, cp0_wdata,
    input  cp0_rdata, interrupt, exception, eret_go, EPC, handler_addr, flush
  );

  modport slave (
    input  hw_int, m_valid, pc_m, bd_m, exc_valid, exc_code, eret_m,
           cp0_we, cp0_addr, cp0_wdata,
    output cp0_rdata, interrupt, exception, eret_go, EPC, handler_addr, flush
  );
endinterface

// File: rtl/cp0_regs.sv
// CP0 SR/Cause/EPC storage with trap/ERET side effects and the MFC0 read mux.
// Trap and ERET updates take precedence over a same-cycle MTC0 write.
module cp0_regs
  import exception_controller_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  hw_int,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        trap,
  input  logic        trap_int,
  input  logic [4:0]  trap_code,
  input  logic        trap_bd,
  input  logic [31:0] trap_pc,
  input  logic        eret,
  output logic [5:0]  sr_im,
  output logic        sr_exl,
  output logic        sr_ie,
  output logic [5:0]  cause_ip,
  output logic [31:0] epc
);

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q;
  logic [4:0]  code_q, code_d;
  logic [31:0] epc_q, epc_d;

  always_comb begin
    im_d   = im_q;
    exl_d  = exl_q;
    ie_d   = ie_q;
    bd_d   = bd_q;
    code_d = code_q;
    epc_d  = epc_q;
    if (trap) begin
      exl_d  = 1'b1;
      epc_d  = trap_bd ? trap_pc - 32'd4 : trap_pc;
      bd_d   = trap_bd;
      code_d = trap_int ? ExcInt : trap_code;
    end else if (eret) begin
      exl_d = 1'b0;
    end else if (we) begin
      case (addr)
        Cp0AddrSr: begin
          im_d  = wdata[15:10];
          exl_d = wdata[1];
          ie_d  = wdata[0];
        end
        Cp0AddrCause: begin
          bd_d   = wdata[31];
          code_d = wdata[6:2];
        end
        Cp0AddrEpc: epc_d = wdata & 32'hFFFF_FFFC;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im_q   <= '0;
      exl_q  <= 1'b0;
      ie_q   <= 1'b0;
      bd_q   <= 1'b0;
      ip_q   <= '0;
      code_q <= '0;
      epc_q  <= '0;
    end else begin
      im_q   <= im_d;
      exl_q  <= exl_d;
      ie_q   <= ie_d;
      bd_q   <= bd_d;
      ip_q   <= hw_int;
      code_q <= code_d;
      epc_q  <= epc_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      Cp0AddrSr:    rdata = {16'b0, im_q, 8'b0, exl_q, ie_q};
      Cp0AddrCause: rdata = {bd_q, 15'b0, ip_q, 3'b0, code_q, 2'b0};
      Cp0AddrEpc:   rdata = epc_q;
      Cp0AddrPrid:  rdata = PridValue;
      default:      rdata = '0;
    endcase
  end

  assign sr_im    = im_q;
  assign sr_exl   = exl_q;
  assign sr_ie    = ie_q;
  assign cause_ip = ip_q;
  assign epc      = epc_q;

endmodule

// File: rtl/exception_controller.sv
// Decides interrupt/exception/ERET for the M-stage instruction, drives the
// next-PC select and flush, and sequences the one-cycle post-trap flush.
module exception_controller
  import exception_controller_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = DefaultHandlerAddr
) (
  input logic                   clk,
  input logic                   reset,
  exception_controller_if.slave bus
);

  state_e      state_q;
  logic        run;
  logic        int_req, exc_req, eret_req;
  logic        take_int, take_exc;
  logic [5:0]  sr_im, cause_ip;
  logic        sr_exl, sr_ie;
  logic [31:0] epc;

  // Gating on reset keeps the combinational controls low while reset is held.
  assign run      = reset & (state_q == StRun) & bus.m_valid;
  assign int_req  = run & sr_ie & ~sr_exl & (|(cause_ip & sr_im));
  assign exc_req  = run & bus.exc_valid & ~sr_exl;
  assign eret_req = run & bus.eret_m;

  assign take_int = int_req & ~eret_req;
  assign take_exc = exc_req & ~eret_req & ~int_req;

  assign bus.eret_go      = eret_req;
  assign bus.interrupt    = take_int;
  assign bus.exception    = take_exc;
  assign bus.flush        = eret_req | take_int | take_exc | (state_q == StFlush);
  assign bus.EPC          = epc;
  assign bus.handler_addr = HANDLER_ADDR;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StRun;
    end else begin
      case (state_q)
        StRun:   if (take_int | take_exc | eret_req) state_q <= StFlush;
        StFlush: state_q <= StRun;
        default: state_q <= StRun;
      endcase
    end
  end

  cp0_regs u_cp0_regs (
    .clk       (clk),
    .reset     (reset),
    .hw_int    (bus.hw_int),
    .we        (bus.cp0_we),
    .addr      (bus.cp0_addr),
    .wdata     (bus.cp0_wdata),
    .rdata     (bus.cp0_rdata),
    .trap      (take_int | take_exc),
    .trap_int  (take_int),
    .trap_code (bus.exc_code),
    .trap_bd   (bus.bd_m),
    .trap_pc   (bus.pc_m),
    .eret      (eret_req),
    .sr_im     (sr_im),
    .sr_exl    (sr_exl),
    .sr_ie     (sr_ie),
    .cause_ip  (cause_ip),
    .epc       (epc)
  );

endmodule

// File: tb/tb_exception_controller.sv
// Scoreboard bench for exception_controller: expectations are queued when a
// stimulus slot is driven and popped when the DUT output is sampled.
module tb_exception_controller;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  exception_controller_if bus ();

  exception_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      check_val("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check_val(e.tag, obs, e.val);
    end
  endtask

  // {interrupt, exception, eret_go, flush}
  task automatic ctl(input string tag, input logic [3:0] exp);
    sb_push(tag, {28'b0, exp});
    #1;
    sb_pop({28'b0, bus.interrupt, bus.exception, bus.eret_go, bus.flush});
  endtask

  task automatic rd(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    sb_push(tag, exp);
    bus.cp0_addr = addr;
    #1;
    sb_pop(bus.cp0_rdata);
  endtask

  task automatic epc_port(input string tag, input logic [31:0] exp);
    sb_push(tag, exp);
    sb_pop(bus.EPC);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    bus.hw_int    = '0;
    bus.m_valid   = 1'b0;
    bus.pc_m      = '0;
    bus.bd_m      = 1'b0;
    bus.exc_valid = 1'b0;
    bus.exc_code  = '0;
    bus.eret_m    = 1'b0;
    bus.cp0_we    = 1'b0;
    bus.cp0_addr  = '0;
    bus.cp0_wdata = '0;
    reset = 1'b1;
    #1 reset = 1'b0;

    // Reset state
    ctl("rst_ctl", 4'b0000);
    rd("rst_sr", 5'd12, 32'h0);
    rd("rst_cause", 5'd13, 32'h0);
    rd("rst_epc", 5'd14, 32'h0);
    rd("prid", 5'd15, 32'h4D49_5053);
    rd("addr3", 5'd3, 32'h0);
    sb_push("handler", 32'h0000_4180);
    sb_pop(bus.handler_addr);
    tick();
    reset = 1'b1;

    // Interrupt: SR = IM[10] | IE
    bus.cp0_we = 1'b1; bus.cp0_addr = 5'd12; bus.cp0_wdata = 32'h0000_0401;
    tick();
    bus.cp0_we = 1'b0;
    rd("sr_wr", 5'd12, 32'h0000_0401);
    bus.hw_int = 6'b000001; bus.m_valid = 1'b1; bus.pc_m = 32'h3008;
    ctl("int_sample_lat", 4'b0000);
    tick();
    bus.cp0_we = 1'b1; bus.cp0_addr = 5'd12; bus.cp0_wdata = 32'h0;
    ctl("int_take", 4'b1001);
    tick();
    bus.cp0_we = 1'b0;
    ctl("int_flush", 4'b0001);
    rd("int_epc", 5'd14, 32'h3008);
    rd("int_cause", 5'd13, 32'h0000_0400);
    rd("int_sr_wr_drop", 5'd12, 32'h0000_0403);
    epc_port("int_epc_port", 32'h3008);
    bus.m_valid = 1'b0; bus.hw_int = '0;
    tick();
    ctl("int_done", 4'b0000);

    // ERET with EXL=1
    bus.m_valid = 1'b1; bus.eret_m = 1'b1;
    ctl("eret_go", 4'b0011);
    tick();
    bus.m_valid = 1'b0; bus.eret_m = 1'b0;
    ctl("eret_flush", 4'b0001);
    rd("eret_sr", 5'd12, 32'h0000_0401);
    rd("eret_epc", 5'd14, 32'h3008);
    tick();
    ctl("eret_done", 4'b0000);

    // Exception in delay slot
    bus.m_valid = 1'b1; bus.exc_valid = 1'b1; bus.exc_code = 5'd12;
    bus.bd_m = 1'b1; bus.pc_m = 32'h3010;
    ctl("exc_take", 4'b0101);
    tick();
    ctl("exc_in_flush", 4'b0001);
    rd("exc_epc", 5'd14, 32'h300C);
    rd("exc_cause", 5'd13, 32'h8000_0030);
    rd("exc_sr", 5'd12, 32'h0000_0403);
    tick();
    ctl("exc_exl_block", 4'b0000);
    rd("exc_epc_keep", 5'd14, 32'h300C);
    bus.exc_valid = 1'b0; bus.eret_m = 1'b1;
    ctl("eret2_go", 4'b0011);
    tick();
    bus.m_valid = 1'b0; bus.eret_m = 1'b0;
    ctl("eret2_flush", 4'b0001);
    tick();
    bus.exc_valid = 1'b1;
    ctl("exc_bubble", 4'b0000);
    rd("bubble_cause", 5'd13, 32'h8000_0030);
    rd("bubble_epc", 5'd14, 32'h300C);
    bus.exc_valid = 1'b0; bus.bd_m = 1'b0;

    // ERET beats a pending enabled interrupt; the interrupt follows the flush
    bus.hw_int = 6'b000001;
    tick();
    bus.m_valid = 1'b1; bus.eret_m = 1'b1; bus.pc_m = 32'h3020;
    ctl("eret_over_int", 4'b0011);
    tick();
    bus.eret_m = 1'b0;
    ctl("eret_over_int_flush", 4'b0001);
    tick();
    bus.cp0_we = 1'b1; bus.cp0_addr = 5'd14; bus.cp0_wdata = 32'hDEAD_BEEF;
    ctl("int_after_flush", 4'b1001);
    tick();
    bus.cp0_we = 1'b0; bus.m_valid = 1'b0; bus.hw_int = '0;
    ctl("int2_flush", 4'b0001);
    rd("int2_epc", 5'd14, 32'h3020);
    rd("int2_cause", 5'd13, 32'h0000_0400);
    tick();
    bus.m_valid = 1'b1; bus.eret_m = 1'b1;
    ctl("eret3_go", 4'b0011);
    tick();
    bus.m_valid = 1'b0; bus.eret_m = 1'b0;
    tick();
    ctl("eret3_done", 4'b0000);

    // MTC0 EPC forces low bits clear
    bus.cp0_we = 1'b1; bus.cp0_addr = 5'd14; bus.cp0_wdata = 32'h0000_1237;
    tick();
    bus.cp0_we = 1'b0;
    rd("epc_wr_align", 5'd14, 32'h0000_1234);
    epc_port("epc_port_align", 32'h0000_1234);

    // EPC wrap on pc_m < 4 in delay slot
    bus.m_valid = 1'b1; bus.exc_valid = 1'b1; bus.exc_code = 5'd10;
    bus.bd_m = 1'b1; bus.pc_m = 32'h0000_0002;
    ctl("wrap_take", 4'b0101);
    tick();
    bus.m_valid = 1'b0; bus.exc_valid = 1'b0; bus.bd_m = 1'b0;
    ctl("wrap_flush", 4'b0001);
    rd("wrap_epc", 5'd14, 32'hFFFF_FFFE);
    rd("wrap_cause", 5'd13, 32'h8000_0028);

    // Reset mid-FLUSH with a write pending
    bus.cp0_we = 1'b1; bus.cp0_addr = 5'd12; bus.cp0_wdata = 32'h0000_FC01;
    #1 reset = 1'b0;
    ctl("rst_mid_ctl", 4'b0000);
    rd("rst_mid_sr", 5'd12, 32'h0);
    tick();
    reset = 1'b1;
    bus.cp0_we = 1'b0;
    ctl("rst_rel_ctl", 4'b0000);
    rd("rst_rel_sr", 5'd12, 32'h0);
    rd("rst_rel_cause", 5'd13, 32'h0);
    rd("rst_rel_epc", 5'd14, 32'h0);
    epc_port("rst_rel_epc_port", 32'h0);

    if (sb.size() != 0) check_val("sb_leftover", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/exception_controller.md
EXCEPTION_CONTROLLER -- requirements
Module: exception_controller

Interface
REQ-001 SHALL have parameter HANDLER_ADDR, default 32'h0000_4180, the exception/interrupt entry address driven on handler_addr.
REQ-002 SHALL have ports: clk  in  1  system clock, rising edge.
REQ-003 SHALL have: reset  in  1  asynchronous, active-low (reset==0 resets).
REQ-004 SHALL have: hw_int  in  6  external interrupt lines.
REQ-005 SHALL have: m_valid  in  1  M stage holds a real instruction, not a bubble.
REQ-006 SHALL have: pc_m  in  32  PC of the M-stage instruction; bd_m  in  1  M instruction is in a delay slot.
REQ-007 SHALL have: exc_valid  in  1  M instruction raised an exception; exc_code  in  5  its ExcCode.
REQ-008 SHALL have: eret_m  in  1  M instruction is ERET.
REQ-009 SHALL have: cp0_we  in  1, cp0_addr  in  5, cp0_wdata  in  32  MTC0 write port; cp0_rdata  out  32  MFC0 read data, combinational.
REQ-010 SHALL have: interrupt  out  1, exception  out  1, eret_go  out  1, EPC  out  32, handler_addr  out  32  next-PC select controls; flush  out  1  pipeline flush.

Function
REQ-011 SHALL hold SR (addr 12): IM[15:10], EXL[1], IE[0]; other bits read 0.
REQ-012 SHALL hold Cause (addr 13): BD[31], IP[15:10] read-only, ExcCode[6:2]; other bits 0.
REQ-013 SHALL hold EPC (addr 14), bits [1:0] forced 0 on every write; PRId (addr 15) reads 32'h4D49_5053; other addresses read 0.
REQ-014 SHALL register hw_int into Cause.IP every cycle (one-cycle sampling latency).
REQ-015 SHALL define int_req = state RUN & m_valid & SR.IE & ~SR.EXL & |(Cause.IP & SR.IM).
REQ-016 SHALL define exc_req = state RUN & m_valid & exc_valid & ~SR.EXL.
REQ-017 SHALL define eret_req = state RUN & m_valid & eret_m.
REQ-018 Priority SHALL be eret_req > int_req > exc_req; outputs eret_go, interrupt, exception SHALL be combinational and mutually exclusive.
REQ-019 On a trap edge (interrupt or exception): EXL<=1, EPC<=bd_m ? pc_m-4 : pc_m, Cause.BD<=bd_m, ExcCode<=0 for interrupt else exc_code.
REQ-020 On eret_go edge: EXL<=0; EPC, Cause unchanged.
REQ-021 MTC0 write SHALL be discarded in a cycle where interrupt, exception or eret_go is 1.
REQ-022 FSM states RUN, FLUSH: RUN->FLUSH on trap or eret_go; FLUSH->RUN unconditionally after one cycle.
REQ-023 flush SHALL be 1 in the trap/eret cycle and throughout FLUSH; all requests SHALL be ignored in FLUSH.
REQ-024 EPC output SHALL be the EPC register value, written value visible the cycle after the write edge.
REQ-025 handler_addr SHALL equal HANDLER_ADDR constantly.
REQ-026 EPC arithmetic SHALL be 32-bit unsigned, wrap-around on pc_m<4.

Reset
REQ-027 On reset==0, immediately: SR=0, Cause=0, EPC=0, state=RUN; interrupt, exception, eret_go, flush =0; cp0_rdata reflects cleared registers.
REQ-028 Reset SHALL take effect mid-FLUSH or mid-write with no residual pending request.

Structure
REQ-029 Shared package SHALL hold CP0 register addresses 12-15, ExcCode constants (Int=0, AdEL=4, AdES=5, RI=10, Ov=12), PRId value, default handler address, FSM state encoding.
REQ-030 A single sub-module cp0_regs SHALL hold SR/Cause/EPC storage and the read mux; sequencing FSM stays in exception_controller.

Verification
REQ-031 Write SR=32'h0000_0401, raise hw_int[0], pc_m=32'h3008, m_valid=1 -> interrupt=1 one cycle later; after edge EPC=32'h3008, ExcCode=0, EXL=1, flush high 2 cycles.
REQ-032 exc_valid=1, exc_code=12, bd_m=1, pc_m=32'h3010, EXL=0 -> exception=1; after edge EPC=32'h300C, Cause=32'h8000_0030.
REQ-033 EXL=1, eret_m=1, m_valid=1 -> eret_go=1, interrupt=0; after edge EXL=0, EPC unchanged, FLUSH for 1 cycle.
REQ-034 eret_m=1 with pending enabled interrupt same cycle -> eret_go=1, interrupt=0; interrupt taken on first RUN cycle after FLUSH.
REQ-035 exc_valid=1 during FLUSH, or with EXL=1, or with m_valid=0 -> exception=0, registers unchanged.
REQ-036 reset driven low during FLUSH with cp0_we=1 -> all outputs 0 immediately, SR/Cause/EPC read 0 after release.
